// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core with loadable instruction and data memories.
// Runs from PC 0 on start, halts on the halt opcode or an illegal encoding.
module mips_multicycle_core #(
    parameter int DATA_W     = 8,
    parameter int REG_N      = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int LED_REG    = 2,
    parameter int PC_W       = $clog2(IMEM_DEPTH),
    parameter int DA_W       = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              dload_we,
    input  logic [DA_W-1:0]   dload_addr,
    input  logic [DATA_W-1:0] dload_data,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int RI_W = $clog2(REG_N);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, rdata_q;
    logic [DA_W-1:0]   addr_q;
    logic              busy_q, done_q, err_q;
    logic [DATA_W-1:0] regs_q [REG_N];
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       sext32, daddr32;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   br_target;
    logic              legal, load_ok;
    logic              wb_en, wb_ok;
    logic [4:0]        wb_idx;
    logic [DATA_W-1:0] wb_val;
    logic              unused_bits;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign sext32    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_ext   = sext32[DATA_W-1:0];
    assign daddr32   = 32'(a_q) + sext32;
    // pc_q already holds the branch's own address + 1 by the time EXEC runs
    assign br_target = pc_q + ir_q[PC_W-1:0];
    assign load_ok   = (state_q == IDLE) || (state_q == HALT);
    assign unused_bits = ^{daddr32, sext32, ir_q[10:6]};

    function automatic logic [DATA_W-1:0] reg_rd(input logic [4:0] idx);
        reg_rd = '0;
        if (int'(idx) < REG_N) reg_rd = regs_q[idx[RI_W-1:0]];
    endfunction

    always_comb begin
        legal  = 1'b1;
        wb_en  = 1'b0;
        wb_idx = rt;
        wb_val = rdata_q;
        case (opcode)
            OP_ADDIU: begin
                wb_en  = 1'b1;
                wb_val = a_q + imm_ext;
            end
            OP_RTYPE: begin
                wb_idx = rd;
                case (funct)
                    FN_ADDU: begin
                        wb_en  = 1'b1;
                        wb_val = a_q + b_q;
                    end
                    FN_SLT: begin
                        wb_en  = 1'b1;
                        wb_val = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    end
                    FN_JR:   ;
                    default: legal = 1'b0;
                endcase
            end
            OP_JAL: begin
                wb_en  = (REG_N == 32);
                wb_idx = 5'd31;
                wb_val = DATA_W'(pc_q);
            end
            OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_HALT: ;
            default: legal = 1'b0;
        endcase
        if (state_q == WB) begin
            wb_en  = 1'b1;
            wb_idx = rt;
            wb_val = rdata_q;
        end else if (state_q != EXEC || !legal) begin
            wb_en = 1'b0;
        end
    end

    assign wb_ok = wb_en && (wb_idx != 5'd0) && (int'(wb_idx) < REG_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else begin
            if (wb_ok) regs_q[wb_idx[RI_W-1:0]] <= wb_val;
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                FETCH: begin
                    ir_q    <= imem[pc_q];
                    pc_q    <= pc_q + 1'b1;
                    state_q <= DECODE;
                end
                DECODE: begin
                    a_q     <= reg_rd(rs);
                    b_q     <= reg_rd(rt);
                    state_q <= EXEC;
                end
                EXEC: begin
                    state_q <= FETCH;
                    addr_q  <= daddr32[DA_W-1:0];
                    if (!legal) begin
                        state_q <= HALT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_BEQ:       if (a_q == b_q) pc_q <= br_target;
                            OP_BNE:       if (a_q != b_q) pc_q <= br_target;
                            OP_J, OP_JAL: pc_q <= ir_q[PC_W-1:0];
                            OP_RTYPE:     if (funct == FN_JR) pc_q <= PC_W'(a_q);
                            OP_LW, OP_SW: state_q <= MEM;
                            OP_HALT: begin
                                state_q <= HALT;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM:     state_q <= (opcode == OP_SW) ? FETCH : WB;
                WB:      state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && load_ok) imem[prog_addr] <= prog_data;
    end

    // External loads only happen in IDLE/HALT, core stores only in MEM, so the port never collides
    always_ff @(posedge clk) begin
        if (dload_we && load_ok) begin
            dmem[dload_addr] <= dload_data;
        end else if (state_q == MEM && opcode == OP_SW) begin
            dmem[addr_q] <= b_q;
        end
        rdata_q <= dmem[addr_q];
    end

    generate
        if (LED_REG < REG_N) begin : g_led
            assign led = regs_q[LED_REG];
        end else begin : g_led_none
            assign led = '0;
        end
    endgenerate

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: an 8-bit and a 16-bit core run the same programs side by side.
module tb_mips_multicycle_core;
    localparam int PC_W = 4;
    localparam int DA_W = 4;
    localparam int MAX_CYC = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             prog_we = 1'b0;
    logic [PC_W-1:0]  prog_addr = '0;
    logic [31:0]      prog_data = '0;
    logic             dload_we = 1'b0;
    logic [DA_W-1:0]  dload_addr = '0;
    logic [15:0]      dload_data = '0;
    logic [7:0]       led8;
    logic [15:0]      led16;
    logic             busy8, done8, err8, busy16, done16, err16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    led8;
        int    led16;
        int    err;
        int    cycles;
        int    probe_cyc;
        int    probe_led;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog_q[$];

    always #5 clk = ~clk;

    mips_multicycle_core u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dload_we(dload_we), .dload_addr(dload_addr), .dload_data(dload_data[7:0]),
        .led(led8), .busy(busy8), .done(done8), .err(err8)
    );

    mips_multicycle_core #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dload_we(dload_we), .dload_addr(dload_addr), .dload_data(dload_data),
        .led(led16), .busy(busy16), .done(done16), .err(err16)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] jtype(input int op, input int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < prog_q.size(); i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = PC_W'(i);
            prog_data = prog_q[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
        prog_q.delete();
    endtask

    task automatic dload(input int addr, input int data);
        @(negedge clk);
        dload_we   = 1'b1;
        dload_addr = DA_W'(addr);
        dload_data = 16'(data);
        @(negedge clk);
        dload_we = 1'b0;
    endtask

    task automatic run(input string tag, input int e8, input int e16, input int eerr, input int ecyc,
                       input int probe_cyc = -1, input int probe_led = 0, input bit busy_wr = 1'b0);
        exp_t e;
        int   c8;
        int   c16;
        e.tag = tag; e.led8 = e8; e.led16 = e16; e.err = eerr; e.cycles = ecyc;
        e.probe_cyc = probe_cyc; e.probe_led = probe_led;
        sb_q.push_back(e);
        c8 = 0;
        c16 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, busy8, 1);
        check({tag, "_done_clr"}, done8, 0);
        check({tag, "_err_clr"}, err8, 0);
        for (int k = 1; k <= MAX_CYC; k++) begin
            @(negedge clk);
            if (c8 == 0 && done8) c8 = k;
            if (c16 == 0 && done16) c16 = k;
            if (k == probe_cyc) check({tag, "_probe_led"}, led8, probe_led);
            if (busy_wr && k == 2) begin
                prog_we    = 1'b1;
                prog_addr  = 4'd3;
                prog_data  = itype(9, 0, 2, 99);
                dload_we   = 1'b1;
                dload_addr = 4'd4;
                dload_data = 16'd99;
            end
            if (busy_wr && k == 3) begin
                prog_we  = 1'b0;
                dload_we = 1'b0;
            end
            if (c8 != 0 && c16 != 0) break;
        end
        e = sb_q.pop_front();
        $display("run %s: led8=%0d led16=%0d err=%0d/%0d cycles=%0d/%0d", e.tag, led8, led16, err8, err16, c8, c16);
        check({e.tag, "_cycles8"}, c8, e.cycles);
        check({e.tag, "_cycles16"}, c16, e.cycles);
        check({e.tag, "_led8"}, led8, e.led8);
        check({e.tag, "_led16"}, led16, e.led16);
        check({e.tag, "_err8"}, err8, e.err);
        check({e.tag, "_err16"}, err16, e.err);
        check({e.tag, "_busy_off"}, busy8, 0);
    endtask

    initial begin
        #1;
        check("rst_led8", led8, 0);
        check("rst_led16", led16, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_busy", busy8, 0);
        check("idle_done", done8, 0);

        // straight line
        prog_q.push_back(itype(9, 0, 2, 5));
        prog_q.push_back(itype(9, 2, 2, 3));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("straight", 8, 8, 0, 9, 3, 5);

        // array sum over dmem[0..9]
        for (int i = 0; i < 10; i++) dload(i, i);
        prog_q.push_back(itype(9, 0, 2, 0));
        prog_q.push_back(itype(9, 0, 3, 0));
        prog_q.push_back(itype(9, 0, 4, 10));
        prog_q.push_back(itype(6'h23, 3, 5, 0));
        prog_q.push_back(rtype(2, 5, 2, 6'h21));
        prog_q.push_back(itype(9, 3, 3, 1));
        prog_q.push_back(rtype(3, 4, 6, 6'h2A));
        prog_q.push_back(itype(5, 6, 0, -5));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("array_sum", 45, 45, 0, 182);

        // modulo wrap
        prog_q.push_back(itype(9, 0, 2, 200));
        prog_q.push_back(itype(9, 0, 3, 100));
        prog_q.push_back(rtype(2, 3, 2, 6'h21));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("wrap_add", 44, 300, 0, 12);

        // signed compare plus branches: not taken, taken skip, taken to PC+1
        prog_q.push_back(itype(9, 0, 3, 255));
        prog_q.push_back(itype(9, 0, 4, 1));
        prog_q.push_back(itype(4, 3, 4, 1));
        prog_q.push_back(rtype(3, 4, 2, 6'h2A));
        prog_q.push_back(itype(4, 0, 0, 1));
        prog_q.push_back(itype(9, 0, 2, 7));
        prog_q.push_back(itype(4, 0, 0, 0));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("slt_branch", 1, 0, 0, 21);

        // jal / sw / jr / lw: r2 = dmem[3] + r31 = 77 + 2
        prog_q.push_back(itype(9, 0, 2, 77));
        prog_q.push_back(jtype(3, 5));
        prog_q.push_back(itype(6'h23, 0, 7, 3));
        prog_q.push_back(rtype(7, 31, 2, 6'h21));
        prog_q.push_back(jtype(6'h3F, 0));
        prog_q.push_back(itype(6'h2B, 0, 2, 3));
        prog_q.push_back(rtype(31, 0, 0, 6'h08));
        load_prog();
        run("call_store", 79, 79, 0, 24);

        // illegal opcode
        prog_q.push_back(itype(9, 0, 2, 9));
        prog_q.push_back(jtype(6'h3E, 0));
        prog_q.push_back(itype(9, 0, 2, 1));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("illegal", 9, 9, 1, 6);
        check("illegal_done", done8, 1);

        // memory writes while busy must be dropped; restart reproduces the result
        prog_q.push_back(itype(9, 0, 8, 1));
        prog_q.push_back(itype(9, 0, 8, 1));
        prog_q.push_back(itype(6'h23, 0, 2, 4));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        run("busy_wr", 4, 4, 0, 14, -1, 0, 1'b1);
        run("restart", 4, 4, 0, 14);

        // reset during lw writeback
        prog_q.push_back(itype(6'h23, 0, 2, 5));
        prog_q.push_back(jtype(6'h3F, 0));
        load_prog();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", led8, 0);
        check("async_rst_busy", busy8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("run reset_in_wb: led8=%0d led16=%0d busy=%0d", led8, led16, busy8);
        check("wb_rst_led8", led8, 0);
        check("wb_rst_led16", led16, 0);
        check("wb_rst_busy", busy8, 0);
        check("wb_rst_done", done8, 0);
        run("after_reset", 5, 5, 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
